// File: rtl/uart_rx_packet_if.sv
// Receive-side bundle for uart_rx_packet: serial input plus the assembled-packet outputs.
// master = the receiver, which drives the packet outputs; slave = the consumer or test driver.
interface uart_rx_packet_if #(
  parameter int W_OUT = 16
) ();
  logic             rx;
  logic             m_valid;
  logic [W_OUT-1:0] m_data;
  logic             frame_err;

  modport master (input rx, output m_valid, output m_data, output frame_err);
  modport slave  (output rx, input m_valid, input m_data, input frame_err);
endinterface

// File: rtl/uart_rx_packet.sv
// UART receiver that assembles W_OUT/BITS_PER_WORD 8N1 words into one packet; word 0 lands in the LSBs.
// Define UART_PARITY_EN to expect one even-parity bit after the data bits of every word.
module uart_rx_packet #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int W_OUT            = 16,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  uart_rx_packet_if.master bus
);
  /* state     | meaning
     S_IDLE    | line idle, waiting for a falling edge
     S_START   | timing to mid start bit to reject glitches
     S_DATA    | sampling data bits mid-bit, LSB first
     S_PARITY  | sampling even-parity bit (UART_PARITY_EN only)
     S_STOP    | sampling stop bit; store word or flag framing error
     S_RECOVER | after a bad stop bit, waiting for the line to return high */

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W     = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
  } state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_s_q, rx_s_d;
  logic [CNT_W-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]         word_idx_q, word_idx_d;
  logic [W_OUT-1:0]         pkt_q, pkt_d;
  logic [W_OUT-1:0]         m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     stop_ok;
`ifdef UART_PARITY_EN
  logic                     par_err_q, par_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_idx_q  <= '0;
      pkt_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      word_idx_q  <= word_idx_d;
      pkt_q       <= pkt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  always_comb begin
    rx_meta_d   = bus.rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_idx_d  = word_idx_q;
    pkt_d       = pkt_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d   = par_err_q;
    stop_ok     = rx_s_q & ~par_err_q;
`else
    stop_ok     = rx_s_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[BITS_PER_WORD-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          par_err_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          if (stop_ok) begin
            pkt_d[int'(word_idx_q)*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
            if (word_idx_q == IDX_LAST) begin
              m_data_d   = pkt_d;
              m_valid_d  = 1'b1;
              word_idx_d = '0;
            end else begin
              word_idx_d = word_idx_q + IDX_W'(1);
            end
            state_d = S_IDLE;
          end else begin
            // A low line after a bad frame is a break, not a new start bit.
            frame_err_d = 1'b1;
            word_idx_d  = '0;
            state_d     = rx_s_q ? S_IDLE : S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet: serializes 8N1 words onto rx and checks the assembled packets.
module tb_uart_rx_packet;
  localparam int CPP = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_packet_if #(.W_OUT(16)) bus ();

  uart_rx_packet #(
    .CLOCKS_PER_PULSE(CPP),
    .W_OUT(16),
    .BITS_PER_WORD(8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          vcnt = 0;
  int          fcnt = 0;
  int          both = 0;
  logic [15:0] last_data = '0;
  time         valid_t = 0;
  time         stop_t = 0;
  int          v0, f0, lat;
`ifdef UART_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  always @(negedge clk) begin
    if (bus.m_valid === 1'b1) begin
      vcnt++;
      last_data = bus.m_data;
      valid_t   = $time;
    end
    if (bus.frame_err === 1'b1) fcnt++;
    if (bus.m_valid === 1'b1 && bus.frame_err === 1'b1) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPP) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * CPP) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    stop_t = $time;
    send_bit(stop);
  endtask

  initial begin
    bus.rx = 1'b1;
    rstn   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_m_valid",   {31'd0, bus.m_valid},   32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("reset_m_data",    {16'd0, bus.m_data},    32'h0000);
    rstn = 1'b1;
    idle_bits(2);

    // 0x34 then 0x12 with 5 idle bits between
    v0 = vcnt; f0 = fcnt;
    send_word(8'h34, 1'b1);
    idle_bits(5);
    send_word(8'h12, 1'b1);
    idle_bits(2);
    check("pkt_valid_count", vcnt - v0, 1);
    check("pkt_data", {16'd0, last_data}, 32'h1234);
    check("pkt_no_ferr", fcnt - f0, 0);
    lat = int'((valid_t - stop_t) / 10);
    check("pkt_latency_window", {31'd0, (lat >= 11 && lat <= 13)}, 32'd1);
    check("pkt_data_stable", {16'd0, bus.m_data}, 32'h1234);

    // back-to-back frames, as a looped-back tx would send 16'hA5C3
    v0 = vcnt;
    send_word(8'hC3, 1'b1);
    send_word(8'hA5, 1'b1);
    idle_bits(2);
    check("b2b_valid_count", vcnt - v0, 1);
    check("b2b_data", {16'd0, last_data}, 32'hA5C3);

    // 4-cycle low glitch
    v0 = vcnt; f0 = fcnt;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(20);
    check("glitch_no_valid", vcnt - v0, 0);
    check("glitch_no_ferr", fcnt - f0, 0);
    check("glitch_data_hold", {16'd0, bus.m_data}, 32'hA5C3);

    // good word 0, then bad stop on word 1, then a break
    v0 = vcnt; f0 = fcnt;
    send_word(8'h77, 1'b1);
    send_word(8'h55, 1'b0);
    bus.rx = 1'b0;
    repeat (30 * CPP) @(negedge clk);
    idle_bits(2);
    check("badstop_ferr_count", fcnt - f0, 1);
    check("badstop_no_valid", vcnt - v0, 0);
    send_word(8'h01, 1'b1);
    send_word(8'h02, 1'b1);
    idle_bits(2);
    check("badstop_next_count", vcnt - v0, 1);
    check("badstop_next_data", {16'd0, last_data}, 32'h0201);

    // reset during the data bits of word 1
    send_word(8'h11, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.rx = 1'b1;
    rstn   = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_m_data", {16'd0, bus.m_data}, 32'h0000);
    check("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    rstn = 1'b1;
    idle_bits(3);
    v0 = vcnt;
    send_word(8'hEF, 1'b1);
    send_word(8'hBE, 1'b1);
    idle_bits(2);
    check("midrst_valid_count", vcnt - v0, 1);
    check("midrst_data", {16'd0, last_data}, 32'hBEEF);

`ifdef UART_PARITY_EN
    v0 = vcnt; f0 = fcnt;
    par_flip = 1'b1;
    send_word(8'h07, 1'b1);
    par_flip = 1'b0;
    idle_bits(2);
    check("parity_ferr", fcnt - f0, 1);
    check("parity_no_valid", vcnt - v0, 0);
    send_word(8'h07, 1'b1);
    send_word(8'h08, 1'b1);
    idle_bits(2);
    check("parity_good_data", {16'd0, last_data}, 32'h0807);
`endif

    check("valid_ferr_exclusive", both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
